// File: rtl/mmio_periph.sv
// mmio_periph: memory-mapped peripheral block on the MEM-stage data bus.
// Holds a reloading 32-bit timer (TH/TL/TCON) with a level interrupt,
// a 16-bit LED register, a 16-bit display register and a free-running
// 32-bit SYSTICK counter.
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   reset      asynchronous, active-high reset
//   addr       byte address from the MEM-stage ALU result
//   wdata      store data from the MEM stage
//   mem_read   load strobe, one cycle per load
//   mem_write  store strobe, one cycle per store
//   rdata      combinational read data, 0 when not reading a valid register
//   led        LED register contents
//   digi       display value for the 7-segment driver
//   irq        timer interrupt request, level
//
// Register map (byte offset from BASE)
//   0x00 TH       reload value, R/W
//   0x04 TL       counter, R/W
//   0x08 TCON     [0] enable, [1] irq-enable, [2] status (write 0 to clear)
//   0x0C LED      [15:0], R/W
//   0x10 DIGI     [15:0], R/W
//   0x14 SYSTICK  read-only free-running counter

module mmio_periph #(
  parameter logic [31:0] BASE = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic [15:0] led,
  output logic [15:0] digi,
  output logic        irq
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PORT_W = 16;
  localparam int unsigned TCON_W = 3;
  localparam int unsigned IDX_W  = 3;

  localparam logic [IDX_W-1:0] IDX_TH      = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_TL      = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_TCON    = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_LED     = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_DIGI    = IDX_W'(4);
  localparam logic [IDX_W-1:0] IDX_SYSTICK = IDX_W'(5);

  localparam int unsigned TCON_EN   = 0;
  localparam int unsigned TCON_IE   = 1;
  localparam int unsigned TCON_STAT = 2;

  logic [DATA_W-1:0] th;
  logic [DATA_W-1:0] tl;
  logic [TCON_W-1:0] tcon;
  logic [PORT_W-1:0] led_q;
  logic [PORT_W-1:0] digi_q;
  logic [DATA_W-1:0] systick;

  logic [DATA_W-1:0] tl_next;
  logic [TCON_W-1:0] tcon_next;

  // Address decode: block match on addr[31:5], word-aligned only.
  logic             hit;
  logic [IDX_W-1:0] idx;

  assign hit = (addr[31:5] == BASE[31:5]) && (addr[1:0] == 2'b00);
  assign idx = addr[4:2];

  logic we_th, we_tl, we_tcon, we_led, we_digi;

  assign we_th   = mem_write && hit && (idx == IDX_TH);
  assign we_tl   = mem_write && hit && (idx == IDX_TL);
  assign we_tcon = mem_write && hit && (idx == IDX_TCON);
  assign we_led  = mem_write && hit && (idx == IDX_LED);
  assign we_digi = mem_write && hit && (idx == IDX_DIGI);

  // Timer events from the registered state of this cycle.
  logic tl_max;
  logic tl_ovf;
  logic stat_set;

  assign tl_max   = (tl == {DATA_W{1'b1}});
  assign tl_ovf   = tcon[TCON_EN] && tl_max;
  assign stat_set = tl_ovf && tcon[TCON_IE];

  // TL next value: software write beats reload, reload beats increment.
  always_comb begin
    tl_next = tl;
    if (we_tl) begin
      tl_next = wdata;
    end else if (tl_ovf) begin
      tl_next = th;
    end else if (tcon[TCON_EN]) begin
      tl_next = tl + DATA_W'(1);
    end
  end

  // TCON next value: status is write-0-to-clear, and a hardware set in the
  // same cycle wins over a clearing write.
  always_comb begin
    tcon_next = tcon;
    if (we_tcon) begin
      tcon_next[TCON_EN]   = wdata[TCON_EN];
      tcon_next[TCON_IE]   = wdata[TCON_IE];
      tcon_next[TCON_STAT] = (tcon[TCON_STAT] && wdata[TCON_STAT]) || stat_set;
    end else begin
      tcon_next[TCON_STAT] = tcon[TCON_STAT] || stat_set;
    end
  end

  // Timer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (we_th) begin
        th <= wdata;
      end
      tl   <= tl_next;
      tcon <= tcon_next;
    end
  end

  // LED and display registers; upper store bits are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q  <= '0;
      digi_q <= '0;
    end else begin
      if (we_led) begin
        led_q <= wdata[PORT_W-1:0];
      end
      if (we_digi) begin
        digi_q <= wdata[PORT_W-1:0];
      end
    end
  end

  // Free-running SYSTICK; wraps naturally and ignores stores.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      systick <= '0;
    end else begin
      systick <= systick + DATA_W'(1);
    end
  end

  // Read mux: a load that coincides with a store returns 0.
  always_comb begin
    rdata = '0;
    if (mem_read && !mem_write && hit) begin
      case (idx)
        IDX_TH:      rdata = th;
        IDX_TL:      rdata = tl;
        IDX_TCON:    rdata = DATA_W'(tcon);
        IDX_LED:     rdata = DATA_W'(led_q);
        IDX_DIGI:    rdata = DATA_W'(digi_q);
        IDX_SYSTICK: rdata = systick;
        default:     rdata = '0;
      endcase
    end
  end

  assign led  = led_q;
  assign digi = digi_q;
  assign irq  = tcon[TCON_IE] && tcon[TCON_STAT];

endmodule
